// File: rtl/multi_blinker.sv
// Multi-channel LED blinker: per-channel off/steady/blink/burst modes sharing one
// programmable half-period. All outputs come straight from registers.
module multi_blinker #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int BURST_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   switch,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CNT_W-1:0]      half_period,
    input  logic [BURST_W-1:0]    burst_len,
    output logic [CHANNELS-1:0]   out,
    output logic [CHANNELS-1:0]   done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HIGH = 2'b01,
        S_LOW  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [1:0] M_OFF    = 2'b00;
    localparam logic [1:0] M_STEADY = 2'b01;
    localparam logic [1:0] M_BLINK  = 2'b10;
    localparam logic [1:0] M_BURST  = 2'b11;

    // Terminal phase count; a half_period of 0 behaves as 1.
    logic [CNT_W-1:0] w_hp_m1;
    assign w_hp_m1 = (half_period == '0) ? '0 : half_period - CNT_W'(1);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_t             r_state, w_state_nx;
        logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
        logic [BURST_W-1:0] r_left, w_left_nx;
        logic               r_out, w_out_nx;
        logic               r_done, w_done_nx;
        logic               r_sw_q;
        logic [1:0]         r_mode_q;
        logic [1:0]         w_mode;
        logic               w_sw;
        logic               w_restart;
        logic               w_phase_end;

        assign w_mode      = mode[2*gi +: 2];
        assign w_sw        = switch[gi];
        assign w_restart   = !w_sw || (w_mode != r_mode_q);
        // >= rather than == so a shrinking half_period still ends the phase.
        assign w_phase_end = (r_cnt >= w_hp_m1);

        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = r_cnt;
            w_left_nx  = r_left;
            w_out_nx   = r_out;
            w_done_nx  = r_done;
            if (w_restart) begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
                w_out_nx   = 1'b0;
                w_done_nx  = 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_out_nx = 1'b0;
                        case (w_mode)
                            M_OFF:    w_out_nx = 1'b0;
                            M_STEADY: w_out_nx = 1'b1;
                            M_BLINK: begin
                                w_out_nx   = 1'b1;
                                w_cnt_nx   = '0;
                                w_state_nx = S_HIGH;
                            end
                            M_BURST: begin
                                // Only a fresh rising edge of the switch triggers a burst.
                                if (!r_sw_q) begin
                                    if (burst_len == '0) begin
                                        w_state_nx = S_DONE;
                                        w_done_nx  = 1'b1;
                                    end else begin
                                        w_out_nx   = 1'b1;
                                        w_left_nx  = burst_len;
                                        w_cnt_nx   = '0;
                                        w_state_nx = S_HIGH;
                                    end
                                end
                            end
                            default: w_out_nx = 1'b0;
                        endcase
                    end
                    S_HIGH: begin
                        if (w_phase_end) begin
                            w_cnt_nx   = '0;
                            w_out_nx   = 1'b0;
                            w_state_nx = S_LOW;
                        end else begin
                            w_cnt_nx = r_cnt + CNT_W'(1);
                        end
                    end
                    S_LOW: begin
                        if (w_phase_end) begin
                            w_cnt_nx = '0;
                            if (w_mode == M_BURST) begin
                                w_left_nx = r_left - BURST_W'(1);
                                if (r_left == BURST_W'(1)) begin
                                    w_state_nx = S_DONE;
                                    w_done_nx  = 1'b1;
                                end else begin
                                    w_out_nx   = 1'b1;
                                    w_state_nx = S_HIGH;
                                end
                            end else begin
                                w_out_nx   = 1'b1;
                                w_state_nx = S_HIGH;
                            end
                        end else begin
                            w_cnt_nx = r_cnt + CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        w_out_nx  = 1'b0;
                        w_done_nx = 1'b1;
                    end
                    default: w_state_nx = S_IDLE;
                endcase
            end
        end

        // mode_q tracks the live mode through reset so that a mode held steady
        // across reset is not seen as a change on the first edge afterwards.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_left   <= '0;
                r_out    <= 1'b0;
                r_done   <= 1'b0;
                r_sw_q   <= 1'b0;
                r_mode_q <= w_mode;
            end else begin
                r_state  <= w_state_nx;
                r_cnt    <= w_cnt_nx;
                r_left   <= w_left_nx;
                r_out    <= w_out_nx;
                r_done   <= w_done_nx;
                r_sw_q   <= w_sw;
                r_mode_q <= w_mode;
            end
        end

        assign out[gi]  = r_out;
        assign done[gi] = r_done;
    end

endmodule
